// File: rtl/sdram_ioctl_loader.sv
// Merges the 8-bit ioctl download stream into 16-bit toggle-handshake SDRAM word writes.
// Optional macro SDRAM_LOADER_CHECKSUM_EN adds a running 16-bit checksum output of the written words.
module sdram_ioctl_loader #(
    parameter logic [22:0] BASE_WADDR = 23'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [23:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [22:0] mem_a,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    output logic        done,
`ifdef SDRAM_LOADER_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic        overrun
);

    typedef enum logic [1:0] {S_IDLE, S_MERGE, S_ISSUE, S_WAIT} state_t;

    state_t      r_state;
    logic [22:0] r_pwA;
    logic [15:0] r_pwD;
    logic [1:0]  r_pwM;
    logic        r_skidV;
    logic [22:0] r_skidA;
    logic        r_skidLane;
    logic [7:0]  r_skidD;
    logic        r_endFlush;
    logic        r_dlPrev;
    logic        r_memReq;
    logic        r_memWe;
    logic [22:0] r_memA;
    logic [1:0]  r_memDs;
    logic [15:0] r_memD;
    logic        r_done;
    logic        r_overrun;

    logic [22:0] w_byteWa;
    logic [1:0]  w_laneM;
    logic        w_wrEn;
    logic        w_dlRise;
    logic        w_dlFall;
    logic        w_ackNow;
    logic        w_absorb;
    logic [22:0] w_baseA;
    logic [15:0] w_baseD;
    logic [1:0]  w_baseM;
    logic        w_fits;
    logic [22:0] w_newA;
    logic [15:0] w_newD;
    logic [1:0]  w_newM;

    assign w_byteWa = ioctl_addr[23:1] + BASE_WADDR;
    assign w_laneM  = ioctl_addr[0] ? 2'b10 : 2'b01;
    assign w_wrEn   = ioctl_wr & ioctl_download;
    assign w_dlRise = ioctl_download & ~r_dlPrev;
    assign w_dlFall = ~ioctl_download & r_dlPrev;
    assign w_ackNow = (r_state == S_WAIT) && (mem_ack == r_memReq);
    assign w_absorb = (r_state == S_IDLE) || (r_state == S_MERGE) || w_ackNow;

    // On the ack cycle the skid byte becomes the merge base before the incoming byte is considered.
    always_comb begin
        w_baseA = r_pwA;
        w_baseD = r_pwD;
        w_baseM = r_pwM;
        if (w_ackNow) begin
            if (r_skidV) begin
                w_baseA = r_skidA;
                w_baseD = r_skidLane ? {r_skidD, 8'h00} : {8'h00, r_skidD};
                w_baseM = r_skidLane ? 2'b10 : 2'b01;
            end else begin
                w_baseM = 2'b00;
            end
        end
        w_fits = (w_baseM == 2'b00) || ((w_baseA == w_byteWa) && ((w_baseM & w_laneM) == 2'b00));
        w_newA = (w_baseM == 2'b00) ? w_byteWa : w_baseA;
        w_newM = w_baseM | w_laneM;
        w_newD = ioctl_addr[0] ? {ioctl_dout, w_baseD[7:0]} : {w_baseD[15:8], ioctl_dout};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pwA      <= '0;
            r_pwD      <= '0;
            r_pwM      <= '0;
            r_skidV    <= 1'b0;
            r_skidA    <= '0;
            r_skidLane <= 1'b0;
            r_skidD    <= '0;
            r_endFlush <= 1'b0;
            r_dlPrev   <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memA     <= '0;
            r_memDs    <= '0;
            r_memD     <= '0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_dlPrev <= ioctl_download;
            r_done   <= 1'b0;
            if (w_dlRise) begin
                r_overrun  <= 1'b0;
                r_endFlush <= 1'b0;
            end else if (w_dlFall) begin
                r_endFlush <= 1'b1;
            end

            if (w_absorb) begin
                if (w_ackNow) begin
                    r_memWe <= 1'b0;
                end
                if (w_wrEn && w_fits) begin
                    r_pwA   <= w_newA;
                    r_pwD   <= w_newD;
                    r_pwM   <= w_newM;
                    r_skidV <= 1'b0;
                    r_state <= (w_newM == 2'b11) ? S_ISSUE : S_MERGE;
                end else if (w_wrEn) begin
                    r_pwA      <= w_baseA;
                    r_pwD      <= w_baseD;
                    r_pwM      <= w_baseM;
                    r_skidV    <= 1'b1;
                    r_skidA    <= w_byteWa;
                    r_skidLane <= ioctl_addr[0];
                    r_skidD    <= ioctl_dout;
                    r_state    <= S_ISSUE;
                end else begin
                    r_pwA   <= w_baseA;
                    r_pwD   <= w_baseD;
                    r_pwM   <= w_baseM;
                    r_skidV <= 1'b0;
                    if (w_baseM == 2'b00) begin
                        r_state <= S_IDLE;
                        if (((r_state == S_IDLE) && w_dlFall) || (w_ackNow && (r_endFlush || w_dlFall))) begin
                            r_done     <= 1'b1;
                            r_endFlush <= 1'b0;
                        end
                    end else if ((r_state == S_MERGE) && !ioctl_download) begin
                        r_endFlush <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_state <= S_MERGE;
                    end
                end
            end else begin
                if (r_state == S_ISSUE) begin
                    r_memA   <= r_pwA;
                    r_memD   <= r_pwD;
                    r_memDs  <= r_pwM;
                    r_memWe  <= 1'b1;
                    r_memReq <= ~r_memReq;
                    r_state  <= S_WAIT;
                end
                // While a request is in flight the skid holds one byte; anything beyond is dropped.
                if (w_wrEn) begin
                    if (r_skidV) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_skidV    <= 1'b1;
                        r_skidA    <= w_byteWa;
                        r_skidLane <= ioctl_addr[0];
                        r_skidD    <= ioctl_dout;
                    end
                end
            end
        end
    end

`ifdef SDRAM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_dlRise) begin
            r_checksum <= '0;
        end else if (w_ackNow) begin
            r_checksum <= r_checksum + (r_memD & {{8{r_memDs[1]}}, {8{r_memDs[0]}}});
        end
    end

    assign checksum = r_checksum;
`endif

    assign ioctl_wait = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && (r_skidV || (r_pwM == 2'b11));
    assign mem_req    = r_memReq;
    assign mem_we     = r_memWe;
    assign mem_a      = r_memA;
    assign mem_ds     = r_memDs;
    assign mem_d      = r_memD;
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sdram_ioctl_loader.sv
// Self-checking bench for sdram_ioctl_loader: directed cases plus randomized downloads
// compared against a byte-grouping reference model of the expected word writes.
module tb_sdram_ioctl_loader;

   localparam logic [22:0] TB_BASE = 23'h7FFFFF;

   typedef struct packed {
      logic [23:0] addr;
      logic [7:0]  data;
   } byte_t;

   typedef struct packed {
      logic [22:0] a;
      logic [15:0] d;
      logic [1:0]  ds;
      logic        we;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [23:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        mem_req;
   logic        mem_ack;
   logic        mem_we;
   logic [22:0] mem_a;
   logic [1:0]  mem_ds;
   logic [15:0] mem_d;
   logic        done;
   logic        overrun;
`ifdef SDRAM_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
   logic [15:0] doneSum;
`endif

   int    checks = 0;
   int    failures = 0;
   int    reqCount = 0;
   int    doneCount = 0;
   int    doneWrites = 0;
   logic  doneIdle = 1'b0;
   int    ackDelay = 3;
   bit    ackRandom = 1'b0;
   logic  lastReq;
   byte_t byteQ[$];
   wr_t   obsQ[$];
   wr_t   expQ[$];
   logic [15:0] expSum;

   sdram_ioctl_loader #(.BASE_WADDR(TB_BASE)) dut (
      .clk(clk),
      .reset(reset),
      .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait),
      .mem_req(mem_req),
      .mem_ack(mem_ack),
      .mem_we(mem_we),
      .mem_a(mem_a),
      .mem_ds(mem_ds),
      .mem_d(mem_d),
      .done(done),
`ifdef SDRAM_LOADER_CHECKSUM_EN
      .checksum(checksum),
`endif
      .overrun(overrun)
   );

   // Free-running system clock shared with the modelled SDRAM controller
   always #5 clk = ~clk;

   // Modelled SDRAM port: answers each request toggle after a fixed or random delay
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            mem_ack = 1'b0;
         end else if (mem_req != mem_ack) begin
            int dly;
            dly = ackRandom ? int'($urandom_range(1, 8)) : ackDelay;
            for (int k = 1; k < dly; k++) begin
               @(posedge clk);
               if (reset) break;
            end
            #2;
            mem_ack = reset ? 1'b0 : mem_req;
         end
      end
   end

   // Records every issued write at its request toggle and the circumstances of each done pulse
   initial begin
      wr_t w;
      lastReq = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            lastReq = 1'b0;
         end else begin
            if (mem_req !== lastReq) begin
               w.a = mem_a;
               w.d = mem_d;
               w.ds = mem_ds;
               w.we = mem_we;
               obsQ.push_back(w);
               reqCount++;
               lastReq = mem_req;
            end
            if (done) begin
               doneCount++;
               doneWrites = obsQ.size();
               doneIdle = (mem_req == mem_ack);
`ifdef SDRAM_LOADER_CHECKSUM_EN
               doneSum = checksum;
`endif
            end
         end
      end
   end

   // Global time bound so a stuck design can never hang the run
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one byte strobe; an honouring source first waits for ioctl_wait to drop
   task automatic applyStimulus(input logic [23:0] addr, input logic [7:0] data, input bit honour);
      int    waited;
      byte_t b;
      waited = 0;
      while (honour && ioctl_wait && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 500) checkOutput("waitBound", 32'(waited), 32'(0));
      ioctl_wr = 1'b1;
      ioctl_addr = addr;
      ioctl_dout = data;
      if (honour) begin
         b.addr = addr;
         b.data = data;
         byteQ.push_back(b);
      end
      @(negedge clk);
      ioctl_wr = 1'b0;
   endtask

   task automatic pushWord(input logic [22:0] a, input logic [15:0] d, input logic [1:0] ds);
      wr_t w;
      w.a = a;
      w.d = d;
      w.ds = ds;
      w.we = 1'b1;
      expQ.push_back(w);
      expSum = expSum + d;
   endtask

   // Reference model: walk accepted bytes in order, grouping them into word writes
   task automatic buildExpected();
      logic [22:0] ga;
      logic [15:0] gd;
      logic [1:0]  gm;
      logic [22:0] wa;
      logic [1:0]  lm;
      expQ.delete();
      expSum = 16'h0000;
      ga = '0;
      gd = '0;
      gm = '0;
      foreach (byteQ[i]) begin
         wa = 23'(byteQ[i].addr[23:1] + TB_BASE);
         lm = byteQ[i].addr[0] ? 2'b10 : 2'b01;
         if (gm != 2'b00 && (wa != ga || (gm & lm) != 2'b00)) begin
            pushWord(ga, gd, gm);
            gm = '0;
            gd = '0;
         end
         if (gm == 2'b00) ga = wa;
         if (lm == 2'b10) gd[15:8] = byteQ[i].data;
         else gd[7:0] = byteQ[i].data;
         gm = gm | lm;
         if (gm == 2'b11) begin
            pushWord(ga, gd, gm);
            gm = '0;
            gd = '0;
         end
      end
      if (gm != 2'b00) pushWord(ga, gd, gm);
   endtask

   task automatic startDownload();
      byteQ.delete();
      obsQ.delete();
      doneCount = 0;
      ioctl_download = 1'b1;
      @(negedge clk);
   endtask

   // Ends the download, waits for done and compares everything written against the model
   task automatic finishDownload(input logic expOverrun);
      int t;
      logic [15:0] m;
      ioctl_download = 1'b0;
      t = 0;
      while (doneCount == 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      checkOutput("doneSeen", 32'(doneCount > 0), 32'(1));
      repeat (3) @(negedge clk);
      buildExpected();
      checkOutput("doneCount", 32'(doneCount), 32'(1));
      checkOutput("doneAfterAck", 32'(doneIdle), 32'(1));
      checkOutput("doneAfterLast", 32'(doneWrites), 32'(expQ.size()));
      checkOutput("nWrites", 32'(obsQ.size()), 32'(expQ.size()));
      checkOutput("overrun", 32'(overrun), 32'(expOverrun));
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
         m = {{8{expQ[i].ds[1]}}, {8{expQ[i].ds[0]}}};
         checkOutput($sformatf("wrA[%0d]", i), 32'(obsQ[i].a), 32'(expQ[i].a));
         checkOutput($sformatf("wrDs[%0d]", i), 32'(obsQ[i].ds), 32'(expQ[i].ds));
         checkOutput($sformatf("wrD[%0d]", i), 32'(obsQ[i].d & m), 32'(expQ[i].d));
         checkOutput($sformatf("wrWe[%0d]", i), 32'(obsQ[i].we), 32'(1));
      end
`ifdef SDRAM_LOADER_CHECKSUM_EN
      checkOutput("checksumAtDone", 32'(doneSum), 32'(expSum));
`endif
   endtask

   initial begin
      int r0;
      logic [23:0] ra;
      int n;
      reset = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      repeat (3) @(negedge clk);
      checkOutput("rstWait", 32'(ioctl_wait), 32'(0));
      checkOutput("rstReq", 32'(mem_req), 32'(0));
      checkOutput("rstWe", 32'(mem_we), 32'(0));
      checkOutput("rstA", 32'(mem_a), 32'(0));
      checkOutput("rstDs", 32'(mem_ds), 32'(0));
      checkOutput("rstD", 32'(mem_d), 32'(0));
      checkOutput("rstDone", 32'(done), 32'(0));
      checkOutput("rstOverrun", 32'(overrun), 32'(0));
`ifdef SDRAM_LOADER_CHECKSUM_EN
      checkOutput("rstChecksum", 32'(checksum), 32'(0));
`endif
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] four bytes, two full words, latency and base wrap");
      ackRandom = 1'b0;
      ackDelay = 3;
      startDownload();
      applyStimulus(24'd0, 8'h11, 1'b1);
      applyStimulus(24'd1, 8'h22, 1'b1);
      r0 = reqCount;
      checkOutput("latBefore", 32'(reqCount), 32'(r0));
      @(posedge clk);
      #2;
      checkOutput("latToggle", 32'(reqCount), 32'(r0 + 1));
      checkOutput("waitHigh", 32'(ioctl_wait), 32'(1));
      @(negedge clk);
      applyStimulus(24'd2, 8'h33, 1'b1);
      applyStimulus(24'd3, 8'h44, 1'b1);
      finishDownload(1'b0);
      checkOutput("t1Count", 32'(obsQ.size()), 32'(2));
      if (obsQ.size() >= 2) begin
         checkOutput("t1A0", 32'(obsQ[0].a), 32'h7FFFFF);
         checkOutput("t1D0", 32'(obsQ[0].d), 32'h2211);
         checkOutput("t1Ds0", 32'(obsQ[0].ds), 32'h3);
         checkOutput("t1A1wrap", 32'(obsQ[1].a), 32'h000000);
         checkOutput("t1D1", 32'(obsQ[1].d), 32'h4433);
      end

      $display("[TB] three bytes, partial flush at end of download");
      startDownload();
      applyStimulus(24'd0, 8'hAA, 1'b1);
      applyStimulus(24'd1, 8'hBB, 1'b1);
      applyStimulus(24'd2, 8'hCC, 1'b1);
      finishDownload(1'b0);
      if (obsQ.size() >= 2) begin
         checkOutput("t2Ds1", 32'(obsQ[1].ds), 32'h1);
         checkOutput("t2D1lo", 32'(obsQ[1].d[7:0]), 32'hCC);
      end
`ifdef SDRAM_LOADER_CHECKSUM_EN
      checkOutput("t2Checksum", 32'(checksum), 32'hBC76);
`endif

      $display("[TB] strobe outside a download is ignored");
      r0 = reqCount;
      applyStimulus(24'd6, 8'h5A, 1'b0);
      repeat (10) @(negedge clk);
      checkOutput("ignoredWr", 32'(reqCount), 32'(r0));

      $display("[TB] bytes at 5 then 8, different words");
      startDownload();
      applyStimulus(24'd5, 8'h55, 1'b1);
      applyStimulus(24'd8, 8'h88, 1'b1);
      finishDownload(1'b0);
      if (obsQ.size() >= 2) begin
         checkOutput("t4Ds0", 32'(obsQ[0].ds), 32'h2);
         checkOutput("t4Ds1", 32'(obsQ[1].ds), 32'h1);
      end

      $display("[TB] overrun while request in flight");
      ackDelay = 20;
      startDownload();
      applyStimulus(24'd0, 8'h01, 1'b1);
      applyStimulus(24'd1, 8'h02, 1'b1);
      applyStimulus(24'd2, 8'h03, 1'b0);
      applyStimulus(24'd3, 8'h04, 1'b0);
      begin
         byte_t b;
         b.addr = 24'd2;
         b.data = 8'h03;
         byteQ.push_back(b);
      end
      checkOutput("overrunSet", 32'(overrun), 32'(1));
      finishDownload(1'b1);
      startDownload();
      checkOutput("overrunClr", 32'(overrun), 32'(0));
      finishDownload(1'b0);

      $display("[TB] reset during WAIT");
      startDownload();
      applyStimulus(24'd0, 8'h77, 1'b1);
      applyStimulus(24'd1, 8'h66, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("inFlight", 32'(mem_req != mem_ack), 32'(1));
      reset = 1'b1;
      ioctl_download = 1'b0;
      #1;
      checkOutput("midRstWait", 32'(ioctl_wait), 32'(0));
      checkOutput("midRstReq", 32'(mem_req), 32'(0));
      checkOutput("midRstWe", 32'(mem_we), 32'(0));
      checkOutput("midRstA", 32'(mem_a), 32'(0));
      checkOutput("midRstDs", 32'(mem_ds), 32'(0));
      checkOutput("midRstD", 32'(mem_d), 32'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      r0 = reqCount;
      repeat (30) @(negedge clk);
      checkOutput("noReqAfterRst", 32'(reqCount), 32'(r0));
      checkOutput("reqLowAfterRst", 32'(mem_req), 32'(0));

      $display("[TB] randomized downloads");
      ackRandom = 1'b1;
      for (int run = 0; run < 8; run++) begin
         startDownload();
         n = (run == 0) ? 0 : int'($urandom_range(5, 60));
         ra = 24'($urandom);
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 9))
               7: ra = 24'($urandom);
               8: ra = ra;
               9: ra = ra + 24'd2;
               default: ra = ra + 24'd1;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(ra, 8'($urandom), 1'b1);
         end
         finishDownload(1'b0);
      end

      $display("[TB] 256 sequential bytes with slow ack");
      ackRandom = 1'b0;
      ackDelay = 20;
      startDownload();
      for (int k = 0; k < 256; k++) begin
         applyStimulus(24'(k), 8'($urandom), 1'b1);
      end
      finishDownload(1'b0);
      checkOutput("seqCount", 32'(obsQ.size()), 32'(128));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
